// File: rtl/axi_interconnect_rr_if.sv
// Bundles the upstream AR/R/AC masters and the single downstream port of the RR read interconnect.
// slave modport faces the interconnect; master modport faces the surrounding fabric.
interface axi_interconnect_rr_if #(
    parameter int ID_WIDTH   = 13,
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int NUM_M      = 2
);
    logic [NUM_M*ID_WIDTH-1:0]   s_arid;
    logic [NUM_M*ADDR_WIDTH-1:0] s_araddr;
    logic [NUM_M*8-1:0]          s_arlen;
    logic [NUM_M*3-1:0]          s_arsize;
    logic [NUM_M*2-1:0]          s_arburst;
    logic [NUM_M-1:0]            s_arvalid;
    logic [NUM_M-1:0]            s_arready;
    logic [ID_WIDTH-1:0]         s_rid;
    logic [DATA_WIDTH-1:0]       s_rdata;
    logic [1:0]                  s_rresp;
    logic                        s_rlast;
    logic [NUM_M-1:0]            s_rvalid;
    logic [NUM_M-1:0]            s_rready;
    logic [NUM_M-1:0]            s_acvalid;
    logic [NUM_M-1:0]            s_acready;
    logic [ADDR_WIDTH-1:0]       s_acaddr;
    logic [3:0]                  s_acsnoop;
    logic [ID_WIDTH-1:0]         m_arid;
    logic [ADDR_WIDTH-1:0]       m_araddr;
    logic [7:0]                  m_arlen;
    logic [2:0]                  m_arsize;
    logic [1:0]                  m_arburst;
    logic                        m_arvalid;
    logic                        m_arready;
    logic [ID_WIDTH-1:0]         m_rid;
    logic [DATA_WIDTH-1:0]       m_rdata;
    logic [1:0]                  m_rresp;
    logic                        m_rlast;
    logic                        m_rvalid;
    logic                        m_rready;
    logic                        m_acvalid;
    logic [ADDR_WIDTH-1:0]       m_acaddr;
    logic [3:0]                  m_acsnoop;
    logic                        m_acready;

    modport slave (
        input  s_arid, s_araddr, s_arlen, s_arsize, s_arburst, s_arvalid, s_rready, s_acready,
        input  m_arready, m_rid, m_rdata, m_rresp, m_rlast, m_rvalid, m_acvalid, m_acaddr, m_acsnoop,
        output s_arready, s_rid, s_rdata, s_rresp, s_rlast, s_rvalid, s_acvalid, s_acaddr, s_acsnoop,
        output m_arid, m_araddr, m_arlen, m_arsize, m_arburst, m_arvalid, m_rready, m_acready
    );

    modport master (
        output s_arid, s_araddr, s_arlen, s_arsize, s_arburst, s_arvalid, s_rready, s_acready,
        output m_arready, m_rid, m_rdata, m_rresp, m_rlast, m_rvalid, m_acvalid, m_acaddr, m_acsnoop,
        input  s_arready, s_rid, s_rdata, s_rresp, s_rlast, s_rvalid, s_acvalid, s_acaddr, s_acsnoop,
        input  m_arid, m_araddr, m_arlen, m_arsize, m_arburst, m_arvalid, m_rready, m_acready
    );
endinterface

// File: rtl/axi_interconnect_rr.sv
// Round-robin AR arbiter with ID-based R return routing and all-master snoop ack collection.
// Latency: AR 1 cycle valid->m_arvalid; R and AC combinational pass-through (0 cycles).
// Backpressure: grant held until m_arready; R follows selected s_rready; AC completes once every master acked.
module axi_interconnect_rr #(
    parameter int ID_WIDTH   = 13,
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int NUM_M      = 2,
    parameter int IDX_W      = $clog2(NUM_M)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    axi_interconnect_rr_if.slave bus
);
    typedef enum logic {IDLE, BUSY} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]   pick;
    logic               pick_vld;
    logic [IDX_W-1:0]   r_sel;
    logic [NUM_M-1:0]   acked_q, acked_d;
    logic [NUM_M-1:0]   ac_hs;
    logic               ac_done;

    // Two passes give the first requester at or after rr_ptr, wrapping to index 0.
    always_comb begin
        pick_vld = 1'b0;
        pick     = '0;
        for (int j = 0; j < NUM_M; j++) begin
            if (!pick_vld && (IDX_W'(j) >= rr_ptr_q) && bus.s_arvalid[j]) begin
                pick_vld = 1'b1;
                pick     = IDX_W'(j);
            end
        end
        for (int j = 0; j < NUM_M; j++) begin
            if (!pick_vld && (IDX_W'(j) < rr_ptr_q) && bus.s_arvalid[j]) begin
                pick_vld = 1'b1;
                pick     = IDX_W'(j);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    grant_d = pick;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (bus.m_arready) begin
                    state_d  = IDLE;
                    rr_ptr_d = (grant_q == IDX_W'(NUM_M - 1)) ? '0 : grant_q + IDX_W'(1);
                end
            end
        endcase
    end

    // AR fields follow the registered grant; the low ID bits carry the master index for R return.
    always_comb begin
        bus.m_arvalid = (state_q == BUSY);
        bus.s_arready = '0;
        bus.m_arid    = '0;
        bus.m_araddr  = '0;
        bus.m_arlen   = '0;
        bus.m_arsize  = '0;
        bus.m_arburst = '0;
        for (int i = 0; i < NUM_M; i++) begin
            if (grant_q == IDX_W'(i)) begin
                bus.m_arid         = bus.s_arid[i*ID_WIDTH +: ID_WIDTH];
                bus.m_araddr       = bus.s_araddr[i*ADDR_WIDTH +: ADDR_WIDTH];
                bus.m_arlen        = bus.s_arlen[i*8 +: 8];
                bus.m_arsize       = bus.s_arsize[i*3 +: 3];
                bus.m_arburst      = bus.s_arburst[i*2 +: 2];
                bus.s_arready[i]   = (state_q == BUSY) && bus.m_arready;
            end
        end
        bus.m_arid[IDX_W-1:0] = grant_q;
    end

    // An index beyond NUM_M matches no master, so m_rready stays 1 and the beat is dropped.
    always_comb begin
        r_sel        = bus.m_rid[IDX_W-1:0];
        bus.s_rvalid = '0;
        bus.m_rready = 1'b1;
        for (int i = 0; i < NUM_M; i++) begin
            if (r_sel == IDX_W'(i)) begin
                bus.s_rvalid[i] = bus.m_rvalid;
                bus.m_rready    = bus.s_rready[i];
            end
        end
    end

    assign bus.s_rid     = bus.m_rid;
    assign bus.s_rdata   = bus.m_rdata;
    assign bus.s_rresp   = bus.m_rresp;
    assign bus.s_rlast   = bus.m_rlast;
    assign bus.s_acaddr  = bus.m_acaddr;
    assign bus.s_acsnoop = bus.m_acsnoop;

    // Snoop completes in the cycle the last outstanding master handshakes, then the ack set clears.
    always_comb begin
        bus.s_acvalid = {NUM_M{bus.m_acvalid}} & ~acked_q;
        ac_hs         = bus.s_acvalid & bus.s_acready;
        ac_done       = bus.m_acvalid && (&(acked_q | ac_hs));
        bus.m_acready = ac_done && reset_n;
        acked_d       = ac_done ? '0 : (acked_q | ac_hs);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
            acked_q  <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            acked_q  <= acked_d;
        end
    end
endmodule

// File: tb/tb_axi_interconnect_rr.sv
// Scoreboarded bench: expected AR grants are queued as stimulus is applied and checked at each handshake.
module tb_axi_interconnect_rr;
    typedef struct {
        logic [12:0] id;
        logic [63:0] addr;
        logic [7:0]  len;
    } ar_exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_chk = 0;
    int   n_pass = 0;
    ar_exp_t exp_q[$];
    ar_exp_t e_mon;

    logic [12:0] arid_m [2] = '{13'h1235, 13'h0442};
    logic [63:0] addr_m [2] = '{64'h0000_1000_0000_0040, 64'h0000_2000_0000_0080};
    logic [7:0]  len_m  [2] = '{8'h10, 8'h11};
    logic [1:0]  ac_rdy_tab [7] = '{2'b01, 2'b00, 2'b00, 2'b10, 2'b00, 2'b11, 2'b00};
    logic [1:0]  ac_vld_tab [7] = '{2'b11, 2'b10, 2'b10, 2'b10, 2'b11, 2'b11, 2'b11};
    logic        ac_ack_tab [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    always #5 clk = ~clk;

    axi_interconnect_rr_if #(.NUM_M(2)) b ();
    axi_interconnect_rr_if #(.NUM_M(3)) b3 ();

    axi_interconnect_rr #(.NUM_M(2)) dut (.clk(clk), .reset_n(reset_n), .bus(b.slave));
    axi_interconnect_rr #(.NUM_M(3)) dut3 (.clk(clk), .reset_n(reset_n), .bus(b3.slave));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic ar_exp_t exp_for(input int g);
        ar_exp_t e;
        e.id    = arid_m[g];
        e.id[0] = g[0];
        e.addr  = addr_m[g];
        e.len   = len_m[g];
        return e;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (reset_n && b.m_arvalid && b.m_arready) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_grant", 64'(b.m_arid), 64'h1fff_ffff);
            end else begin
                e_mon = exp_q.pop_front();
                chk("sb_arid", 64'(b.m_arid), 64'(e_mon.id));
                chk("sb_araddr", b.m_araddr, e_mon.addr);
                chk("sb_arlen", 64'(b.m_arlen), 64'(e_mon.len));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        b.s_arid = {arid_m[1], arid_m[0]};
        b.s_araddr = {addr_m[1], addr_m[0]};
        b.s_arlen = {len_m[1], len_m[0]};
        b.s_arsize = 6'b011_011;
        b.s_arburst = 4'b01_01;
        b.s_arvalid = '0;
        b.s_rready = '0;
        b.s_acready = 2'b11;
        b.m_arready = 1'b0;
        b.m_rid = '0;
        b.m_rdata = '0;
        b.m_rresp = '0;
        b.m_rlast = 1'b0;
        b.m_rvalid = 1'b0;
        b.m_acvalid = 1'b1;
        b.m_acaddr = 64'hdead_beef_0000_1000;
        b.m_acsnoop = 4'h3;
        b3.s_arid = '0; b3.s_araddr = '0; b3.s_arlen = '0; b3.s_arsize = '0; b3.s_arburst = '0;
        b3.s_arvalid = '0; b3.s_rready = '0; b3.s_acready = '0; b3.m_arready = 1'b0;
        b3.m_rid = '0; b3.m_rdata = '0; b3.m_rresp = '0; b3.m_rlast = 1'b0; b3.m_rvalid = 1'b0;
        b3.m_acvalid = 1'b0; b3.m_acaddr = '0; b3.m_acsnoop = '0;

        // Reset state, including m_acready held low despite a would-be complete snoop.
        #3;
        chk("rst_m_arvalid", 64'(b.m_arvalid), 64'd0);
        chk("rst_s_arready", 64'(b.s_arready), 64'd0);
        chk("rst_m_acready", 64'(b.m_acready), 64'd0);
        b.m_acvalid = 1'b0;
        b.s_acready = '0;

        // Both masters requesting continuously: grants alternate with an IDLE cycle between.
        b.s_arvalid = 2'b11;
        b.m_arready = 1'b1;
        for (int k = 0; k < 4; k++) exp_q.push_back(exp_for(k % 2));
        next_cycle();
        reset_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk("alt_m_arvalid", 64'(b.m_arvalid), 64'(c % 2));
            if (c % 2 == 1) chk("alt_s_arready", 64'(b.s_arready), 64'(1 << ((c / 2) % 2)));
            next_cycle();
        end
        b.s_arvalid = '0;

        // Grant to master 1 holds under backpressure while master 0 joins late.
        exp_q.push_back(exp_for(1));
        exp_q.push_back(exp_for(0));
        for (int c = 0; c < 8; c++) begin
            b.s_arvalid = (c >= 2) ? 2'b11 : 2'b10;
            b.m_arready = (c >= 5);
            @(negedge clk);
            if (c >= 1 && c <= 5) begin
                chk("hold_m_arvalid", 64'(b.m_arvalid), 64'd1);
                chk("hold_m_araddr", b.m_araddr, addr_m[1]);
                chk("hold_s_arready0", 64'(b.s_arready[0]), 64'd0);
            end
            if (c == 6) chk("hold_idle_gap", 64'(b.m_arvalid), 64'd0);
            if (c == 7) chk("hold_next_grant", b.m_araddr, addr_m[0]);
            next_cycle();
        end
        b.s_arvalid = '0;

        // Reset mid-BUSY drops the grant; rr_ptr restarts at 0.
        b.s_arvalid = 2'b11;
        b.m_arready = 1'b0;
        @(negedge clk);
        chk("rb_idle", 64'(b.m_arvalid), 64'd0);
        next_cycle();
        @(negedge clk);
        chk("rb_busy", 64'(b.m_arvalid), 64'd1);
        chk("rb_grant1", 64'(b.m_arid[0]), 64'd1);
        next_cycle();
        reset_n = 1'b0;
        #1;
        chk("rb_async_arvalid", 64'(b.m_arvalid), 64'd0);
        chk("rb_async_arready", 64'(b.s_arready), 64'd0);
        #2;
        reset_n = 1'b1;
        b.m_arready = 1'b1;
        exp_q.push_back(exp_for(0));
        @(negedge clk);
        chk("rb_post_idle", 64'(b.m_arvalid), 64'd0);
        next_cycle();
        @(negedge clk);
        chk("rb_post_grant0", 64'(b.m_arid[0]), 64'd0);
        next_cycle();
        b.s_arvalid = '0;

        // R routing by low ID bits.
        b.m_rid = 13'h0003;
        b.m_rdata = 64'h0123_4567_89ab_cdef;
        b.m_rvalid = 1'b1;
        b.s_rready = 2'b10;
        #1;
        chk("r_s_rvalid_m1", 64'(b.s_rvalid), 64'h2);
        chk("r_m_rready_m1", 64'(b.m_rready), 64'd1);
        chk("r_s_rid", 64'(b.s_rid), 64'h3);
        chk("r_s_rdata", b.s_rdata, 64'h0123_4567_89ab_cdef);
        b.s_rready = 2'b01;
        #1;
        chk("r_m_rready_blocked", 64'(b.m_rready), 64'd0);
        b.m_rid = 13'h0a42;
        #1;
        chk("r_s_rvalid_m0", 64'(b.s_rvalid), 64'h1);
        chk("r_m_rready_m0", 64'(b.m_rready), 64'd1);
        b.m_rvalid = 1'b0;

        // Three-master instance: out-of-range index is drained, in-range index routed.
        b3.m_rid = 13'h0003;
        b3.m_rvalid = 1'b1;
        b3.s_rready = 3'b000;
        #1;
        chk("r3_stray_rvalid", 64'(b3.s_rvalid), 64'd0);
        chk("r3_stray_rready", 64'(b3.m_rready), 64'd1);
        b3.m_rid = 13'h1ff6;
        b3.s_rready = 3'b011;
        #1;
        chk("r3_m2_rvalid", 64'(b3.s_rvalid), 64'h4);
        chk("r3_m2_rready", 64'(b3.m_rready), 64'd0);
        chk("r3_s_rid", 64'(b3.s_rid), 64'h1ff6);
        b3.m_rvalid = 1'b0;

        // Snoop ack collection with an AR grant running alongside.
        next_cycle();
        b.m_acvalid = 1'b1;
        exp_q.push_back(exp_for(0));
        for (int c = 0; c < 7; c++) begin
            b.s_acready = ac_rdy_tab[c];
            b.s_arvalid = (c < 2) ? 2'b01 : 2'b00;
            @(negedge clk);
            chk("ac_s_acvalid", 64'(b.s_acvalid), 64'(ac_vld_tab[c]));
            chk("ac_m_acready", 64'(b.m_acready), 64'(ac_ack_tab[c]));
            if (c == 0) chk("ac_s_acaddr", b.s_acaddr, 64'hdead_beef_0000_1000);
            next_cycle();
        end
        b.m_acvalid = 1'b0;
        b.s_acready = '0;

        next_cycle();
        next_cycle();
        chk("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
